pe_idx_loader: RTL and testbench

Write-side companion of the PE address generation unit. It accepts one AGU command plus its stream of sparse index pairs, writes the pairs into the write bank of the AGU's ping-pong index RAM, and waits until the AGU reports done. It then toggles the RAM banks and pulses `start` with the latched command fields. Loading of command N+1 overlaps AGU execution of command N.

---
 rtl/global_param.sv | 31 +++
 rtl/pe_idx_loader.sv | 159 +++++++++++++++
 tb/tb_pe_idx_loader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/global_param.sv
`default_nettype none
// ============================================================================
// Module      : GLOBAL_PARAM (package)
// Description : Shared widths, bit-width helper and the AGU command record.
// Revision    : 1.0 - initial release
// ============================================================================
package GLOBAL_PARAM;

    localparam int IDX_W = 8;

    // Number of address bits needed to index 'value' entries (minimum 1).
    function automatic int bw(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < value) w = w + 1;
        end
        return w;
    endfunction

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] idx_cnt;
        logic [7:0] trip_cnt;
        logic       is_new;
        logic [3:0] pad_code;
        logic       cut_y;
    } agu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/pe_idx_loader.sv
`default_nettype none
// ============================================================================
// Module      : pe_idx_loader
// Description : Loads one AGU command's index pairs into the write bank of the
//               ping-pong index RAM, then swaps banks and starts the AGU.
//               Optional length checking: define IDX_LEN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_idx_loader
    import GLOBAL_PARAM::*;
#(
    parameter int IDX_DEPTH  = 256,
    parameter int IDX_ADDR_W = bw(IDX_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [7:0]            cmd_idx_cnt,
    input  logic [7:0]            cmd_trip_cnt,
    input  logic                  cmd_is_new,
    input  logic [3:0]            cmd_pad_code,
    input  logic                  cmd_cut_y,
    input  logic                  idx_valid,
    output logic                  idx_ready,
    input  logic [IDX_W*2-1:0]    idx_data,
    input  logic                  idx_last,
    output logic [IDX_W*2-1:0]    idx_wr_data,
    output logic [IDX_ADDR_W-1:0] idx_wr_addr,
    output logic                  idx_wr_en,
    output logic                  switch_idx_buf,
    output logic                  start,
    output logic [1:0]            mode,
    output logic [7:0]            idx_cnt,
    output logic [7:0]            trip_cnt,
    output logic                  is_new,
    output logic [3:0]            pad_code,
    output logic                  cut_y,
    input  logic                  agu_done,
    output logic                  len_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SWAP  = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    agu_cmd_t                r_shadow;
    agu_cmd_t                r_fields;
    logic [7:0]              r_cnt;
    logic                    r_wr_en;
    logic [IDX_ADDR_W-1:0]   r_wr_addr;
    logic [IDX_W*2-1:0]      r_wr_data;
    logic                    w_cmd_hs;
    logic                    w_idx_hs;
    logic                    w_cnt_hit;

    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_idx_hs  = idx_valid && idx_ready;
    assign w_cnt_hit = (r_cnt == r_shadow.idx_cnt);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Handshake/pulse outputs are forced low while reset is held.
    always_comb begin
        w_state_nxt    = r_state;
        cmd_ready      = 1'b0;
        idx_ready      = 1'b0;
        switch_idx_buf = 1'b0;
        start          = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    idx_ready = 1'b1;
                    if (idx_valid && w_cnt_hit) w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (agu_done) w_state_nxt = ST_SWAP;
                end
                ST_SWAP: begin
                    switch_idx_buf = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                end
                ST_ISSUE: begin
                    start       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_fields  <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_idx_hs;
            if (w_cmd_hs) begin
                r_shadow <= '{mode: cmd_mode, idx_cnt: cmd_idx_cnt, trip_cnt: cmd_trip_cnt,
                              is_new: cmd_is_new, pad_code: cmd_pad_code, cut_y: cmd_cut_y};
                r_cnt    <= '0;
            end
            // A 256-pair load wraps the counter back to 0; it is cleared on the next command anyway.
            if (w_idx_hs) begin
                r_wr_addr <= IDX_ADDR_W'(r_cnt);
                r_wr_data <= idx_data;
                r_cnt     <= r_cnt + 8'd1;
            end
            if (r_state == ST_SWAP) r_fields <= r_shadow;
        end
    end

    assign idx_wr_en   = r_wr_en;
    assign idx_wr_addr = r_wr_addr;
    assign idx_wr_data = r_wr_data;
    assign mode        = r_fields.mode;
    assign idx_cnt     = r_fields.idx_cnt;
    assign trip_cnt    = r_fields.trip_cnt;
    assign is_new      = r_fields.is_new;
    assign pad_code    = r_fields.pad_code;
    assign cut_y       = r_fields.cut_y;

`ifdef IDX_LEN_CHECK_EN
    logic r_len_err;

    // idx_last must coincide exactly with the counted final pair.
    always_ff @(posedge clk) begin
        if (rst)                                    r_len_err <= 1'b0;
        else if (w_idx_hs && (idx_last != w_cnt_hit)) r_len_err <= 1'b1;
    end

    assign len_err = r_len_err;
`else
    logic w_unused_idx_last;

    assign w_unused_idx_last = idx_last;
    assign len_err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_idx_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_idx_loader
// Description : Self-checking bench for pe_idx_loader with randomized loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_idx_loader;
    import GLOBAL_PARAM::*;

    localparam int DW   = IDX_W * 2;
    localparam int AW   = bw(256);
    localparam int HIST = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = '0;
    logic [7:0]    cmd_idx_cnt = '0;
    logic [7:0]    cmd_trip_cnt = '0;
    logic          cmd_is_new = 1'b0;
    logic [3:0]    cmd_pad_code = '0;
    logic          cmd_cut_y = 1'b0;
    logic          idx_valid = 1'b0;
    logic          idx_ready;
    logic [DW-1:0] idx_data = '0;
    logic          idx_last = 1'b0;
    logic [DW-1:0] idx_wr_data;
    logic [AW-1:0] idx_wr_addr;
    logic          idx_wr_en;
    logic          switch_idx_buf;
    logic          start;
    logic [1:0]    mode;
    logic [7:0]    idx_cnt;
    logic [7:0]    trip_cnt;
    logic          is_new;
    logic [3:0]    pad_code;
    logic          cut_y;
    logic          agu_done = 1'b0;
    logic          len_err;

    pe_idx_loader #(.IDX_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_idx_cnt(cmd_idx_cnt), .cmd_trip_cnt(cmd_trip_cnt), .cmd_is_new(cmd_is_new),
        .cmd_pad_code(cmd_pad_code), .cmd_cut_y(cmd_cut_y),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data), .idx_last(idx_last),
        .idx_wr_data(idx_wr_data), .idx_wr_addr(idx_wr_addr), .idx_wr_en(idx_wr_en),
        .switch_idx_buf(switch_idx_buf), .start(start),
        .mode(mode), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt), .is_new(is_new),
        .pad_code(pad_code), .cut_y(cut_y), .agu_done(agu_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    int            sw_q[$];
    int            st_q[$];
    agu_cmd_t      st_f[$];
    int            hs_q[$];
    logic [DW-1:0] dq[$];
    bit            done_hist[HIST];
    bit            rdy_hist[HIST];
    int            both_cnt = 0;
    int            cmd_hs;
    int            n_cmp = 0;
    int            n_err = 0;

    // Observer: logs what the DUT does each cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < HIST) begin
            done_hist[cyc] = agu_done;
            rdy_hist[cyc]  = idx_ready | cmd_ready;
        end
        if (idx_wr_en === 1'b1) wq.push_back('{cyc, idx_wr_addr, idx_wr_data});
        if (switch_idx_buf === 1'b1) sw_q.push_back(cyc);
        if (start === 1'b1) begin
            st_q.push_back(cyc);
            st_f.push_back({mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y});
        end
        if (switch_idx_buf === 1'b1 && start === 1'b1) both_cnt++;
    end

    task automatic clear_mon();
        wq.delete(); sw_q.delete(); st_q.delete(); st_f.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic agu_cmd_t rand_cmd(input logic [7:0] cnt);
        agu_cmd_t c;
        c = '{mode: 2'($urandom), idx_cnt: cnt, trip_cnt: 8'($urandom), is_new: 1'($urandom),
              pad_code: 4'($urandom), cut_y: 1'($urandom)};
        return c;
    endfunction

    task automatic fill_rand(input int n);
        dq.delete();
        for (int i = 0; i < n; i++) dq.push_back(DW'($urandom));
    endtask

    task automatic do_cmd(input agu_cmd_t c);
        cmd_hs = -1;
        {cmd_mode, cmd_idx_cnt, cmd_trip_cnt, cmd_is_new, cmd_pad_code, cmd_cut_y} = c;
        cmd_valid = 1'b1;
        for (int k = 0; k < 100 && cmd_hs < 0; k++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) cmd_hs = cyc;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_idx(input int n, input int last_pos, input int max_bub, input int stop_after);
        bit got;
        hs_q.delete();
        for (int i = 0; i < n && i < stop_after; i++) begin
            idx_valid = 1'b0;
            repeat ($urandom_range(0, max_bub)) tick();
            idx_valid = 1'b1;
            idx_data  = dq[i];
            idx_last  = (i == last_pos);
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (idx_ready === 1'b1) begin
                    got = 1'b1;
                    hs_q.push_back(cyc);
                end
                tick();
            end
        end
        idx_valid = 1'b0;
        idx_last  = 1'b0;
    endtask

    task automatic run_load(input agu_cmd_t c, input int last_pos, input int max_bub);
        do_cmd(c);
        do_idx(dq.size(), last_pos, max_bub, dq.size());
    endtask

    task automatic wait_start(input int limit);
        for (int k = 0; k < limit && st_q.size() == 0; k++) tick();
        repeat (2) tick();
    endtask

    // Expected write log: pair i lands at address i the cycle after its handshake.
    function automatic int write_errs();
        int e;
        e = 0;
        if (wq.size() != dq.size() || hs_q.size() != dq.size()) return 1000 + wq.size();
        for (int i = 0; i < dq.size(); i++)
            if (wq[i].a !== AW'(i) || wq[i].d !== dq[i] || wq[i].c != hs_q[i] + 1) e++;
        return e;
    endfunction

    // Switch comes one cycle after the first post-load cycle that sees done high.
    function automatic int exp_switch();
        if (hs_q.size() == 0) return -1;
        for (int c = hs_q[hs_q.size()-1] + 1; c < HIST; c++)
            if (done_hist[c]) return c + 1;
        return -1;
    endfunction

    function automatic int first_or_neg(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic test_reset();
        logic [80:0] outs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_cmd_ready_in_reset: got %b want 0", cmd_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready);
        end
        outs = 81'({idx_ready, idx_wr_en, switch_idx_buf, start, len_err, idx_wr_addr, idx_wr_data,
                    mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y});
        n_cmp++;
        if (outs !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        tick();
    endtask

    task automatic test_basic();
        agu_cmd_t c;
        int       e;
        clear_mon();
        agu_done = 1'b1;
        c = rand_cmd(8'd3);
        c.mode = 2'b01;
        dq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        run_load(c, 3, 0);
        wait_start(50);
        e = write_errs();
        n_cmp++;
        if (e != 0) begin n_err++; $display("FAIL basic_writes: %0d bad, want 0", e); end
        n_cmp++;
        if (hs_q.size() != 4 || first_or_neg(sw_q) != hs_q[3] + 2) begin
            n_err++; $display("FAIL basic_switch: got cycle %0d want last write + 1", first_or_neg(sw_q));
        end
        n_cmp++;
        if (first_or_neg(st_q) != cmd_hs + 4 + 3) begin
            n_err++; $display("FAIL basic_latency: start at %0d want %0d", first_or_neg(st_q), cmd_hs + 7);
        end
        n_cmp++;
        if (st_f.size() != 1 || st_f[0] !== c) begin
            n_err++; $display("FAIL basic_fields: got %h want %h", (st_f.size() > 0) ? st_f[0] : '0, c);
        end
    endtask

    task automatic test_agu_busy();
        agu_cmd_t c;
        int       e, rise, sw, bad_rdy;
        clear_mon();
        agu_done = 1'b0;
        c = rand_cmd(8'($urandom_range(0, 7)));
        fill_rand(int'(c.idx_cnt) + 1);
        run_load(c, int'(c.idx_cnt), 2);
        repeat (10) tick();
        rise = cyc;
        agu_done = 1'b1;
        wait_start(50);
        sw = first_or_neg(sw_q);
        e = write_errs();
        n_cmp++;
        if (e != 0) begin n_err++; $display("FAIL busy_writes: %0d bad, want 0", e); end
        n_cmp++;
        if (sw != rise + 1) begin n_err++; $display("FAIL busy_switch: got %0d want %0d", sw, rise + 1); end
        bad_rdy = 0;
        if (hs_q.size() > 0 && sw > 0)
            for (int k = hs_q[hs_q.size()-1] + 1; k <= sw + 1; k++) if (rdy_hist[k]) bad_rdy++;
        n_cmp++;
        if (bad_rdy != 0 || sw < 0) begin
            n_err++; $display("FAIL busy_no_handshake: %0d ready cycles, want 0", bad_rdy);
        end
        n_cmp++;
        if (first_or_neg(st_q) != sw + 1 || st_f.size() != 1 || st_f[0] !== c) begin
            n_err++; $display("FAIL busy_start: got cycle %0d want %0d", first_or_neg(st_q), sw + 1);
        end
    endtask

    // Overlapped traffic: the AGU drops done at each start and raises it at random later.
    task automatic test_back_to_back();
        agu_cmd_t c;
        int       e, esw;
        for (int it = 0; it < 5; it++) begin
            clear_mon();
            c = rand_cmd(8'($urandom_range(0, 20)));
            fill_rand(int'(c.idx_cnt) + 1);
            run_load(c, int'(c.idx_cnt), 1);
            repeat ($urandom_range(0, 5)) tick();
            agu_done = 1'b1;
            wait_start(50);
            agu_done = 1'b0;
            e   = write_errs();
            esw = exp_switch();
            n_cmp++;
            if (e != 0) begin n_err++; $display("FAIL b2b_writes[%0d]: %0d bad, want 0", it, e); end
            n_cmp++;
            if (sw_q.size() != 1 || first_or_neg(sw_q) != esw) begin
                n_err++; $display("FAIL b2b_switch[%0d]: got %0d want %0d", it, first_or_neg(sw_q), esw);
            end
            n_cmp++;
            if (st_q.size() != 1 || first_or_neg(st_q) != esw + 1 || st_f[0] !== c) begin
                n_err++; $display("FAIL b2b_start[%0d]: got %0d want %0d", it, first_or_neg(st_q), esw + 1);
            end
            n_cmp++;
            if (len_err !== 1'b0) begin n_err++; $display("FAIL b2b_len_err[%0d]: got %b want 0", it, len_err); end
        end
        agu_done = 1'b1;
    endtask

    task automatic test_full_depth();
        agu_cmd_t c;
        int       e;
        clear_mon();
        agu_done = 1'b1;
        c = rand_cmd(8'd255);
        fill_rand(256);
        run_load(c, 255, 0);
        wait_start(100);
        repeat (5) tick();
        e = write_errs();
        n_cmp++;
        if (e != 0) begin n_err++; $display("FAIL full_writes: %0d bad, want 0", e); end
        n_cmp++;
        if (sw_q.size() != 1 || st_q.size() != 1) begin
            n_err++; $display("FAIL full_pulses: switch %0d start %0d, want 1 and 1", sw_q.size(), st_q.size());
        end
    endtask

    task automatic test_len_check();
        agu_cmd_t c;
        logic     exp_err;
        int       e;
`ifdef IDX_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_mon();
        agu_done = 1'b1;
        c = rand_cmd(8'd3);
        fill_rand(4);
        run_load(c, 1, 0);
        wait_start(50);
        e = write_errs();
        n_cmp++;
        if (e != 0) begin n_err++; $display("FAIL len_writes: %0d bad, want 0", e); end
        n_cmp++;
        if (len_err !== exp_err) begin n_err++; $display("FAIL len_err_set: got %b want %b", len_err, exp_err); end
        clear_mon();
        c = rand_cmd(8'd2);
        fill_rand(3);
        run_load(c, 2, 1);
        wait_start(50);
        n_cmp++;
        if (len_err !== exp_err) begin n_err++; $display("FAIL len_err_sticky: got %b want %b", len_err, exp_err); end
    endtask

    task automatic test_reset_mid_load();
        agu_cmd_t c;
        int       e, nw;
        clear_mon();
        agu_done = 1'b1;
        c = rand_cmd(8'd3);
        fill_rand(4);
        do_cmd(c);
        do_idx(4, 3, 0, 2);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        nw = wq.size();
        repeat (10) tick();
        n_cmp++;
        if (sw_q.size() != 0 || st_q.size() != 0) begin
            n_err++; $display("FAIL rst_mid_pulses: switch %0d start %0d, want 0 and 0", sw_q.size(), st_q.size());
        end
        n_cmp++;
        if (wq.size() != nw || len_err !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_quiet: writes %0d len_err %b, want %0d and 0", wq.size(), len_err, nw);
        end
        clear_mon();
        c = rand_cmd(8'd3);
        fill_rand(4);
        run_load(c, 3, 1);
        wait_start(50);
        e = write_errs();
        n_cmp++;
        if (e != 0) begin n_err++; $display("FAIL rst_mid_reload: %0d bad, want 0", e); end
    endtask

    task automatic test_pulse_exclusive();
        n_cmp++;
        if (both_cnt != 0) begin n_err++; $display("FAIL pulse_overlap: %0d cycles, want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_agu_busy();
        test_back_to_back();
        test_full_depth();
        test_len_check();
        test_reset_mid_load();
        test_pulse_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
